vec_pack16: RTL and testbench

Upstream feeder for `sum16`. It collects a serial stream of 11-bit element pairs (a, b), one pair per accepted cycle, and assembles them into the 176-bit lane vectors `A`/`B` that `sum16` consumes. When a vector completes, it presents the vector with a one-cycle `pushout` strobe. The next vector fills in parallel with no dead cycles, and short vectors are zero-padded on an explicit `last_in` flush.

---
 rtl/fpsum_pkg.sv | 17 +
 rtl/vec_pack16_if.sv | 18 +
 rtl/vec_pack16.sv | 76 +++++++
 tb/tb_vec_pack16.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/fpsum_pkg.sv
// Shared definitions for the FP11 lane datapath (vec_pack16 feeder and sum16).
package fpsum_pkg;
  localparam int ELEM_W = 11;
  localparam int N_ELEM = 16;
  localparam int VEC_W  = ELEM_W * N_ELEM;
  localparam int CNT_W  = $clog2(N_ELEM);
  localparam int NV_W   = $clog2(N_ELEM) + 1;

  typedef logic [ELEM_W-1:0]             elem_t;
  typedef logic [VEC_W-1:0]              vec_t;
  typedef logic [N_ELEM-1:0][ELEM_W-1:0] lanes_t;

  // FP11 +0: padding lanes contribute nothing to a sum
  localparam elem_t ELEM_ZERO = '0;

  typedef enum logic {ST_EMPTY, ST_FILLING} fill_st_t;
endpackage

// File: rtl/vec_pack16_if.sv
// Element stream in, assembled A/B vector strobe out.
interface vec_pack16_if;
  import fpsum_pkg::*;

  logic            pushin;
  elem_t           a_in;
  elem_t           b_in;
  logic            last_in;
  logic            pushout;
  vec_t            A;
  vec_t            B;
  logic [NV_W-1:0] nvalid;

  modport master (output pushin, a_in, b_in, last_in,
                  input  pushout, A, B, nvalid);
  modport slave  (input  pushin, a_in, b_in, last_in,
                  output pushout, A, B, nvalid);
endinterface

// File: rtl/vec_pack16.sv
// Packs a serial (a,b) element stream into 16-lane A/B vectors, zero-padding
// short vectors on last_in; the next vector fills with no dead cycle.
module vec_pack16
  import fpsum_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  vec_pack16_if.slave  io
);

  logic [CNT_W-1:0] cnt, cnt_nxt;
  lanes_t           asm_a, asm_b, wr_a, wr_b;
  logic [N_ELEM-1:0] lane_en;
  fill_st_t         st;
  logic             done;
  logic [NV_W-1:0]  nv_nxt;

  logic             pushout_q;
  lanes_t           a_q, b_q;
  logic [NV_W-1:0]  nvalid_q;

  // wr_* is the assembly with the current element merged in, so a completing
  // push hands the output registers its own element in the same edge
  for (genvar i = 0; i < N_ELEM; i++) begin : g_lane
    assign lane_en[i] = io.pushin && (cnt == CNT_W'(i));
    assign wr_a[i]    = lane_en[i] ? io.a_in : asm_a[i];
    assign wr_b[i]    = lane_en[i] ? io.b_in : asm_b[i];
  end

  always_comb begin
    st      = (cnt == '0) ? ST_EMPTY : ST_FILLING;
    done    = 1'b0;
    cnt_nxt = cnt;
    nv_nxt  = NV_W'(cnt) + NV_W'(1);
    if (io.pushin) begin
      if (io.last_in || cnt == CNT_W'(N_ELEM - 1)) done = 1'b1;
      else                                         cnt_nxt = cnt + CNT_W'(1);
    end else if (io.last_in && st == ST_FILLING) begin
      done   = 1'b1;
      nv_nxt = NV_W'(cnt);
    end
    if (done) cnt_nxt = '0;
  end

  // Unwritten lanes are already zero because the assembly clears on completion
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt       <= '0;
      asm_a     <= '0;
      asm_b     <= '0;
      pushout_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      nvalid_q  <= '0;
    end else begin
      cnt       <= cnt_nxt;
      pushout_q <= done;
      if (done) begin
        a_q      <= wr_a;
        b_q      <= wr_b;
        nvalid_q <= nv_nxt;
        asm_a    <= '0;
        asm_b    <= '0;
      end else begin
        asm_a    <= wr_a;
        asm_b    <= wr_b;
      end
    end
  end

  assign io.pushout = pushout_q;
  assign io.A       = a_q;
  assign io.B       = b_q;
  assign io.nvalid  = nvalid_q;

endmodule

// File: tb/tb_vec_pack16.sv
// Scoreboard bench for vec_pack16: expected vectors queued at drive time,
// popped and compared on pushout, with due-cycle and hold checks.
module tb_vec_pack16;
  import fpsum_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vec_pack16_if io();

  vec_pack16 dut (.clk(clk), .reset(reset), .io(io));

  typedef struct {
    vec_t            a;
    vec_t            b;
    logic [NV_W-1:0] nv;
    int              cyc;
  } exp_t;

  exp_t   q[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  lanes_t ma, mb;
  int     mcnt = 0;
  vec_t   last_a = '0, last_b = '0;

  task automatic chk(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_emit(input int nv);
    exp_t e;
    e.a = ma; e.b = mb; e.nv = NV_W'(nv); e.cyc = cyc + 1;
    q.push_back(e);
    ma = '0; mb = '0; mcnt = 0;
  endtask

  // drive one cycle at negedge; update the reference model alongside
  task automatic drive(input logic p, input elem_t a, input elem_t b, input logic l);
    io.pushin = p; io.a_in = a; io.b_in = b; io.last_in = l;
    if (p) begin
      ma[mcnt] = a; mb[mcnt] = b;
      if (l || mcnt == N_ELEM - 1) model_emit(mcnt + 1);
      else mcnt++;
    end else if (l && mcnt != 0) begin
      model_emit(mcnt);
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    io.pushin = 1'b1; io.a_in = 11'h155; io.b_in = 11'h2AA; io.last_in = 1'b0;
    ma = '0; mb = '0; mcnt = 0;
    repeat (n) @(negedge clk);
    reset = 1'b1;
  endtask

  // monitor: reset zeros, scoreboard pops, overdue detection, output hold
  initial begin
    logic rs;
    exp_t e;
    forever begin
      @(posedge clk);
      rs = reset;
      cyc++;
      @(negedge clk);
      if (!rs) begin
        chk("rst_pushout", VEC_W'(io.pushout), '0);
        chk("rst_A", io.A, '0);
        chk("rst_B", io.B, '0);
        chk("rst_nvalid", VEC_W'(io.nvalid), '0);
        last_a = '0; last_b = '0;
        q.delete();
      end else begin
        if (q.size() != 0 && q[0].cyc < cyc) begin
          chk("missed_pushout_cyc", VEC_W'(cyc), VEC_W'(q[0].cyc));
          void'(q.pop_front());
        end
        if (io.pushout) begin
          if (q.size() == 0) begin
            chk("unexpected_pushout", VEC_W'(io.pushout), '0);
          end else begin
            e = q.pop_front();
            chk("pushout_cyc", VEC_W'(cyc), VEC_W'(e.cyc));
            chk("vec_A", io.A, e.a);
            chk("vec_B", io.B, e.b);
            chk("nvalid", VEC_W'(io.nvalid), VEC_W'(e.nv));
          end
          last_a = io.A; last_b = io.B;
        end else begin
          chk("hold_A", io.A, last_a);
          chk("hold_B", io.B, last_b);
        end
      end
    end
  end

  initial begin
    lanes_t ea, eb;
    reset = 1'b0;
    io.pushin = 1'b0; io.a_in = '0; io.b_in = '0; io.last_in = 1'b0;
    ma = '0; mb = '0;
    @(negedge clk);

    do_reset(3);

    // ramp vector: lane i of A = i, of B = 16+i
    for (int i = 0; i < N_ELEM; i++) drive(1'b1, elem_t'(i), elem_t'(16 + i), 1'b0);
    io.pushin = 1'b0;
    for (int i = 0; i < N_ELEM; i++) begin
      ea[i] = elem_t'(i); eb[i] = elem_t'(16 + i);
    end
    chk("ramp_pushout", VEC_W'(io.pushout), VEC_W'(1));
    chk("ramp_A_const", io.A, ea);
    chk("ramp_B_const", io.B, eb);
    chk("ramp_nvalid_const", VEC_W'(io.nvalid), VEC_W'(16));

    // two back-to-back full vectors
    for (int i = 0; i < 2 * N_ELEM; i++) drive(1'b1, 11'h3C0, 11'h3C0, 1'b0);

    // short vector closed by last_in on the 5th push
    for (int i = 1; i <= 5; i++) drive(1'b1, elem_t'(i), elem_t'(i + 8), i == 5);
    io.pushin = 1'b0; io.last_in = 1'b0;
    ea = '0;
    for (int i = 0; i < 5; i++) ea[i] = elem_t'(i + 1);
    chk("short_A_const", io.A, ea);
    chk("short_nvalid_const", VEC_W'(io.nvalid), VEC_W'(5));

    // 3 pushes, idle, standalone flush, then flush while empty
    for (int i = 0; i < 3; i++) drive(1'b1, elem_t'(11'h100 + i), elem_t'(11'h200 + i), 1'b0);
    repeat (4) drive(1'b0, '0, '0, 1'b0);
    drive(1'b0, '0, '0, 1'b1);
    chk("flush_nvalid_const", VEC_W'(io.nvalid), VEC_W'(3));
    drive(1'b0, '0, '0, 1'b0);
    drive(1'b0, '0, '0, 1'b1);
    drive(1'b0, '0, '0, 1'b0);
    chk("empty_flush_no_pushout", VEC_W'(io.pushout), '0);

    // consecutive last_in pushes, each a 1-lane vector
    drive(1'b1, 11'h011, 11'h022, 1'b1);
    drive(1'b1, 11'h033, 11'h044, 1'b1);
    // last_in at lane 15 is one completion
    for (int i = 0; i < N_ELEM; i++) drive(1'b1, 11'h055, 11'h066, i == N_ELEM - 1);

    // partial fill discarded by reset
    for (int i = 0; i < 10; i++) drive(1'b1, 11'h123, 11'h321, 1'b0);
    do_reset(1);
    for (int i = 0; i < N_ELEM; i++) drive(1'b1, 11'h7FF, 11'h7FF, 1'b0);
    io.pushin = 1'b0;
    chk("post_rst_A_const", io.A, {VEC_W{1'b1}});
    chk("post_rst_nvalid_const", VEC_W'(io.nvalid), VEC_W'(16));

    repeat (4) drive(1'b0, '0, '0, 1'b0);
    chk("queue_drained", VEC_W'(q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
